sprite_line_buffer: RTL and testbench
=====================================

// Module: sprite_line_buffer
// PURPOSE
// - Ping-pong sprite line buffer sitting directly downstream of video_timing; consumes hc/hbl/vbl with the clk_pix enable.
// - The sprite renderer writes line N+1 into one bank while line N is read out, pixel by pixel, from the other bank.
// - Each read location is cleared behind the read pointer, so every bank starts empty (transparent) for its next fill.
// PARAMETERS
// - DW     12      pixel word width: {palette[DW-5:0], pen[3:0]}
// - AW     8       bank address width; 256 visible pixels per bank
// - TPEN   4'hF    transparent pen value; also the clear value for a location
// PORTS
// - clk        in   1       system clock
// - reset      in   1       asynchronous, active-high
// - clk_pix    in   1       pixel clock enable; one clk wide
// - hc         in   9       horizontal counter from video_timing
// - hbl        in   1       horizontal blank
// - vbl        in   1       vertical blank
// - ready      out  1       high once the post-reset clear sweep has finished
// - line_start out  1       one-clk pulse on the bank swap; the renderer begins its next line on this pulse
// - wr_en      in   1       renderer write strobe; any clk, not gated by clk_pix
// - wr_x       in   9       renderer X position; a write with wr_x[8]=1 is discarded
// - wr_data    in   DW      renderer pixel word
// - pix_out    out  DW      read-out pixel; forced to {0,TPEN} when not visible
// - pix_valid  out  1       pix_out carries a visible pixel
// BEHAVIOUR
// - Reset values: ready=0, line_start=0, pix_out={0,TPEN}, pix_valid=0, bank=0, state=INIT, sweep counter=0.
// - FSM INIT
//   - Write {0,TPEN} to address cnt in both banks on every clk, not gated by clk_pix.
//   - At cnt=2^AW-1, go to RUN and set ready=1 on the next clk.
//   - All wr_en in INIT are dropped.
// - FSM RUN: stays in RUN until reset.
//   - Reset asserted mid-operation returns to INIT and restarts the sweep from 0.
// - Bank swap
//   - The bank flop toggles on a clk_pix cycle where hc==0 and the previous sampled hc!=0.
//   - line_start pulses on that clk.
//   - vc is never used to pick the bank. An odd VTOTAL+1 line count therefore still alternates banks correctly across the frame wrap.
//   - read bank = bank; write bank = ~bank.
// - Renderer write (RUN only)
//   - If wr_en=1, wr_x[8]=0 and wr_data[3:0]!=TPEN: mem[~bank][wr_x[7:0]] <= wr_data.
//   - Transparent writes are skipped, so earlier opaque pixels survive.
//   - Last write wins among opaque writes; no priority compare.
// - Read/clear (RUN, clk_pix=1, hc[8]=0)
//   - Read mem[bank][hc[7:0]].
//   - On the next clk_pix: pix_out <= data and pix_valid <= ~hbl_d & ~vbl_d (blank flags delayed to match).
//   - Latency is exactly one pixel.
//   - Clear: on that same next clk_pix, write {0,TPEN} to mem[bank][prev_addr] through the read-bank write port.
//   - A location is never read and written at the same address in one clk.
//   - Read/clear also runs during vbl, so banks stay clean; pix_valid is 0 there.
// - hc[8]=1 (h blank): no reads. The pending clear for address 255 still issues on the first such clk_pix.
// - Clear and renderer writes always hit different banks. If wr_en coincides with the swap clk, the write goes to the new write bank.
// - When pix_valid=0, pix_out={0,TPEN}.
// STRUCTURE
// - Shared package video_pkg: localparams for DW, AW, TPEN, the CLEAR_WORD, and the INIT/RUN state encoding.
// - Sub-module line_bank_ram: one 2^AW x DW simple dual-port RAM (registered read port, one write port); instantiated twice.
// - Top level holds the FSM, the bank flop, the per-bank write-port mux (init / renderer / clear), and the output registers.
// TESTING
// - Reset, then 256 clks -> ready rises at clk 257; every later read returns {0,F}; wr_en during INIT leaves all-transparent.
// - Write wr_x=10, data 12'h123 during line 0 -> on line 1 at hc=11 pix_out=12'h123, pix_valid=1; the next read of that bank at x=10 returns 12'h00F.
// - Write 12'h123 at x=5, then 12'h04F at x=5 -> readback is 12'h123 (transparent write skipped); wr_x=300 is discarded with no alias at 44.
// - Run 263 lines (vc 0..262) and check bank alternation at the frame wrap: line_start count equals the swap count, and no line reads the bank being written.
// - Assert reset mid-line with opaque data pending -> outputs return to reset values immediately, INIT sweep reruns, and no stale pixel appears after ready.
// - During vbl with the bank preloaded at x=0..3 -> pix_valid=0 and pix_out=12'h00F; the bank reads clean on the following active line.

Source files
------------

// File: rtl/video_pkg.sv
// Shared widths, clear word and FSM encoding for the sprite line buffer.
// Imported by the RAM, the interface and the top level.
package video_pkg;

   localparam int DW = 12;
   localparam int AW = 8;
   localparam logic [3:0] TPEN = 4'hF;
   localparam logic [DW-1:0] CLEAR_WORD = {{(DW-4){1'b0}}, TPEN};

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   function automatic logic is_opaque(input logic [DW-1:0] w);
      return w[3:0] != TPEN;
   endfunction

endpackage

// File: rtl/sprite_line_buffer_if.sv
// Video timing, renderer write and pixel output bundle.
// The master drives timing/writes, the slave (buffer) drives status/pixels.
interface sprite_line_buffer_if
   import video_pkg::*;
();

   logic          clk_pix;
   logic [8:0]    hc;
   logic          hbl;
   logic          vbl;
   logic          wr_en;
   logic [8:0]    wr_x;
   logic [DW-1:0] wr_data;
   logic          ready;
   logic          line_start;
   logic [DW-1:0] pix_out;
   logic          pix_valid;

   modport master (
      output clk_pix, hc, hbl, vbl, wr_en, wr_x, wr_data,
      input  ready, line_start, pix_out, pix_valid
   );

   modport slave (
      input  clk_pix, hc, hbl, vbl, wr_en, wr_x, wr_data,
      output ready, line_start, pix_out, pix_valid
   );

endinterface

// File: rtl/line_bank_ram.sv
// One line bank: 2^AW x DW simple dual-port RAM, registered read port.
// The read register only loads on re_i, so data holds between pixels.
module line_bank_ram
   import video_pkg::*;
(
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [2**AW];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sprite_line_buffer.sv
// Ping-pong sprite line buffer: renderer fills one bank while the other
// is read out one pixel per clk_pix and cleared behind the read pointer.
module sprite_line_buffer
   import video_pkg::*;
(
   input logic                 clk,
   input logic                 reset,
   sprite_line_buffer_if.slave bus
);

   state_e        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          ready_q, ready_d;
   logic          bank_q, bank_d;
   logic          ls_q, ls_d;
   logic [8:0]    hc_prev_q, hc_prev_d;
   logic          rd_pend_q, rd_pend_d;
   logic          rd_bank_q, rd_bank_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic          hbl_q, hbl_d;
   logic          vbl_q, vbl_d;
   logic [DW-1:0] pix_q, pix_d;
   logic          pv_q, pv_d;

   logic          run, swap, rd_go, clr_go, wr_go;
   logic          we    [2];
   logic [AW-1:0] waddr [2];
   logic [DW-1:0] wdata [2];
   logic          re    [2];
   logic [DW-1:0] rdata [2];

   assign run    = state_q == ST_RUN;
   assign swap   = bus.clk_pix && bus.hc == '0 && hc_prev_q != '0;
   assign bank_d = bank_q ^ swap;
   assign rd_go  = run && bus.clk_pix && !bus.hc[8];
   assign clr_go = run && bus.clk_pix && rd_pend_q;
   assign wr_go  = run && bus.wr_en && !bus.wr_x[8]
                   && is_opaque(bus.wr_data);

   // Write-port mux: init sweep, else clear of read bank, else renderer.
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         we[b]    = 1'b0;
         waddr[b] = cnt_q;
         wdata[b] = CLEAR_WORD;
         re[b]    = rd_go && (bank_d == 1'(b));
         if (!run) begin
            we[b] = 1'b1;
         end else if (clr_go && rd_bank_q == 1'(b)) begin
            we[b]    = 1'b1;
            waddr[b] = rd_addr_q;
         end else if (wr_go && bank_d != 1'(b)) begin
            we[b]    = 1'b1;
            waddr[b] = bus.wr_x[AW-1:0];
            wdata[b] = bus.wr_data;
         end
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_bank
      line_bank_ram u_ram (
         .clk     (clk),
         .we_i    (we[g]),
         .waddr_i (waddr[g]),
         .wdata_i (wdata[g]),
         .re_i    (re[g]),
         .raddr_i (bus.hc[AW-1:0]),
         .rdata_o (rdata[g])
      );
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ready_d   = ready_q;
      ls_d      = swap;
      hc_prev_d = hc_prev_q;
      rd_pend_d = rd_pend_q;
      rd_bank_d = rd_bank_q;
      rd_addr_d = rd_addr_q;
      hbl_d     = hbl_q;
      vbl_d     = vbl_q;
      pix_d     = pix_q;
      pv_d      = pv_q;
      if (!run) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == '1) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
         end
      end
      // Blank flags travel with the read so validity lines up with data.
      if (bus.clk_pix) begin
         hc_prev_d = bus.hc;
         rd_pend_d = rd_go;
         rd_bank_d = bank_d;
         rd_addr_d = bus.hc[AW-1:0];
         hbl_d     = bus.hbl;
         vbl_d     = bus.vbl;
         pv_d      = rd_pend_q && !hbl_q && !vbl_q;
         pix_d     = pv_d ? rdata[rd_bank_q] : CLEAR_WORD;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_INIT;
         cnt_q     <= '0;
         ready_q   <= 1'b0;
         bank_q    <= 1'b0;
         ls_q      <= 1'b0;
         hc_prev_q <= '0;
         rd_pend_q <= 1'b0;
         rd_bank_q <= 1'b0;
         rd_addr_q <= '0;
         hbl_q     <= 1'b0;
         vbl_q     <= 1'b0;
         pix_q     <= CLEAR_WORD;
         pv_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ready_q   <= ready_d;
         bank_q    <= bank_d;
         ls_q      <= ls_d;
         hc_prev_q <= hc_prev_d;
         rd_pend_q <= rd_pend_d;
         rd_bank_q <= rd_bank_d;
         rd_addr_q <= rd_addr_d;
         hbl_q     <= hbl_d;
         vbl_q     <= vbl_d;
         pix_q     <= pix_d;
         pv_q      <= pv_d;
      end
   end

   assign bus.ready      = ready_q;
   assign bus.line_start = ls_q;
   assign bus.pix_out    = pix_q;
   assign bus.pix_valid  = pv_q;

endmodule

// File: tb/tb_sprite_line_buffer.sv
// Bench for sprite_line_buffer: ping-pong memory model feeding a pixel
// scoreboard, a write/readback vector table and reset/vbl/frame sequences.
module tb_sprite_line_buffer;
   import video_pkg::*;

   typedef struct {
      int            x;
      logic [DW-1:0] d;
      logic          v;
   } rec_t;

   typedef struct packed {
      logic [8:0]    x;
      logic [DW-1:0] d;
   } wr_t;

   typedef struct packed {
      wr_t           w1;
      wr_t           w2;
      logic [7:0]    rx;
      logic [DW-1:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   sprite_line_buffer_if bus ();

   sprite_line_buffer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   logic [DW-1:0] mm [2][256];
   logic          mbank;
   logic [8:0]    mprev;
   rec_t          sb [$];
   wr_t           wq [$];
   logic [DW-1:0] seen [256];
   int            ls_cnt = 0;
   int            sw_cnt = 0;
   vec_t          tv [6];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      mbank = 1'b0;
      mprev = '0;
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < 256; i++)
            mm[b][i] = CLEAR_WORD;
      sb.delete();
      wq.delete();
   endtask

   // One pixel: a clk_pix clk (with an optional queued write) then an idle clk.
   task automatic pix(input logic [8:0] h, input logic hb, input logic vb);
      logic sw;
      rec_t r;
      rec_t e;
      wr_t  w;
      sw = (h == 9'd0) && (mprev != 9'd0);
      if (sw) begin
         mbank = ~mbank;
         sw_cnt++;
      end
      mprev = h;
      bus.wr_en = 1'b0;
      if (wq.size() > 0) begin
         w = wq.pop_front();
         bus.wr_en = 1'b1;
         bus.wr_x = w.x;
         bus.wr_data = w.d;
         if (!w.x[8] && w.d[3:0] != TPEN)
            mm[~mbank][w.x[7:0]] = w.d;
      end
      r.x = -1;
      r.d = CLEAR_WORD;
      r.v = 1'b0;
      if (!h[8]) begin
         if (!hb && !vb) begin
            r.x = int'(h);
            r.d = mm[mbank][h[7:0]];
            r.v = 1'b1;
         end
         mm[mbank][h[7:0]] = CLEAR_WORD;
      end
      bus.clk_pix = 1'b1;
      bus.hc = h;
      bus.hbl = hb;
      bus.vbl = vb;
      tick();
      chk("line_start", {31'd0, bus.line_start}, {31'd0, sw});
      if (bus.line_start) ls_cnt++;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("pix_out", {20'd0, bus.pix_out}, {20'd0, e.d});
         chk("pix_valid", {31'd0, bus.pix_valid}, {31'd0, e.v});
         if (e.v) seen[e.x] = bus.pix_out;
      end
      sb.push_back(r);
      bus.clk_pix = 1'b0;
      bus.wr_en = 1'b0;
      tick();
      chk("ls_idle", {31'd0, bus.line_start}, 32'd0);
   endtask

   task automatic run_line(input int nvis, input logic vb);
      for (int h = 0; h < nvis; h++) pix(9'(h), 1'b0, vb);
      for (int h = 256; h < 260; h++) pix(9'(h), 1'b1, vb);
   endtask

   task automatic chk_reset_outs(input string nm);
      chk({nm, "_ready"}, {31'd0, bus.ready}, 32'd0);
      chk({nm, "_ls"}, {31'd0, bus.line_start}, 32'd0);
      chk({nm, "_pix"}, {20'd0, bus.pix_out}, {20'd0, CLEAR_WORD});
      chk({nm, "_valid"}, {31'd0, bus.pix_valid}, 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int ls0;
      int sw0;
      tv[0] = {9'd10,  12'h123, 9'd20,  12'h0AB, 8'd10,  12'h123};
      tv[1] = {9'd5,   12'h123, 9'd5,   12'h04F, 8'd5,   12'h123};
      tv[2] = {9'd300, 12'h0AB, 9'd44,  12'h00F, 8'd44,  12'h00F};
      tv[3] = {9'd7,   12'h111, 9'd7,   12'h222, 8'd7,   12'h222};
      tv[4] = {9'd255, 12'h3C1, 9'd0,   12'h3C2, 8'd255, 12'h3C1};
      tv[5] = {9'd0,   12'h3C2, 9'd1,   12'h00F, 8'd0,   12'h3C2};

      bus.clk_pix = 1'b0;
      bus.hc = '0;
      bus.hbl = 1'b0;
      bus.vbl = 1'b0;
      bus.wr_en = 1'b0;
      bus.wr_x = '0;
      bus.wr_data = '0;
      model_reset();

      repeat (3) tick();
      chk_reset_outs("reset");

      // Init sweep with renderer writes hammering; all must be dropped.
      reset = 1'b0;
      for (int i = 1; i <= 256; i++) begin
         bus.wr_en = 1'b1;
         bus.wr_x = 9'(i % 200);
         bus.wr_data = 12'h5A1;
         tick();
         if (i == 255) chk("ready_early", {31'd0, bus.ready}, 32'd0);
         if (i == 256) chk("ready_rise", {31'd0, bus.ready}, 32'd1);
      end
      bus.wr_en = 1'b0;
      run_line(256, 1'b0);
      run_line(256, 1'b0);

      for (int i = 0; i < 6; i++) begin
         wq.push_back(tv[i].w1);
         wq.push_back(tv[i].w2);
         run_line(256, 1'b0);
         run_line(256, 1'b0);
         chk($sformatf("vec%0d_read", i), {20'd0, seen[tv[i].rx]},
             {20'd0, tv[i].exp});
         run_line(256, 1'b0);
         run_line(256, 1'b0);
         chk($sformatf("vec%0d_clear", i), {20'd0, seen[tv[i].rx]},
             {20'd0, CLEAR_WORD});
      end

      // Preloaded bank read out during vbl, then revisited.
      wq.push_back({9'd0, 12'h1A1});
      wq.push_back({9'd1, 12'h1A2});
      wq.push_back({9'd2, 12'h1A3});
      wq.push_back({9'd3, 12'h1A4});
      run_line(256, 1'b0);
      run_line(256, 1'b1);
      run_line(256, 1'b0);
      run_line(256, 1'b0);
      for (int x = 0; x < 4; x++)
         chk($sformatf("vbl_clean%0d", x), {20'd0, seen[x]},
             {20'd0, CLEAR_WORD});

      // Full 263-line frame with short lines across the wrap.
      ls0 = ls_cnt;
      sw0 = sw_cnt;
      for (int vc = 0; vc < 263; vc++) begin
         wq.push_back({9'd3, 8'(vc), 4'h1});
         run_line(16, vc >= 240);
      end
      chk("frame_ls_vs_swaps", ls_cnt - ls0, sw_cnt - sw0);
      chk("frame_ls_count", ls_cnt - ls0, 263);

      // Reset mid-line with opaque pixels in flight.
      wq.push_back({9'd9, 12'h7A1});
      wq.push_back({9'd20, 12'h7A2});
      run_line(256, 1'b0);
      for (int h = 0; h <= 10; h++) pix(9'(h), 1'b0, 1'b0);
      chk("pre_reset_pix", {20'd0, bus.pix_out}, {20'd0, 12'h7A1});
      #2;
      reset = 1'b1;
      #1;
      chk_reset_outs("midreset");
      tick();
      tick();
      reset = 1'b0;
      model_reset();
      n = 0;
      while (!bus.ready && n < 400) begin
         tick();
         n++;
      end
      chk("ready_rerun", n, 256);
      run_line(256, 1'b0);
      chk("stale9_a", {20'd0, seen[9]}, {20'd0, CLEAR_WORD});
      chk("stale20_a", {20'd0, seen[20]}, {20'd0, CLEAR_WORD});
      run_line(256, 1'b0);
      chk("stale9_b", {20'd0, seen[9]}, {20'd0, CLEAR_WORD});
      chk("stale20_b", {20'd0, seen[20]}, {20'd0, CLEAR_WORD});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
